// File: rtl/wire_sequencer_pkg.sv
// rtl/wire_sequencer_pkg.sv - shared FSM states, colour codes and LFSR constants for wire_sequencer
package wire_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        COL_RED    = 3'd0,
        COL_ORANGE = 3'd1,
        COL_YELLOW = 3'd2,
        COL_GREEN  = 3'd3,
        COL_BLUE   = 3'd4,
        COL_VIOLET = 3'd5
    } colour_t;

    localparam int         NUM_COLOURS = 6;
    localparam logic [7:0] LFSR_SEED   = 8'hA5;
    // Taps x^8 + x^6 + x^5 + x^4 map to bit indices 7, 5, 4, 3.
    localparam logic [7:0] LFSR_TAPS   = 8'b1011_1000;

    function automatic logic [2:0] next_colour(input logic [2:0] c);
        return (c == 3'(NUM_COLOURS - 1)) ? 3'd0 : c + 3'd1;
    endfunction

    function automatic logic [2:0] mod_colours(input logic [2:0] v);
        return (v >= 3'(NUM_COLOURS)) ? v - 3'(NUM_COLOURS) : v;
    endfunction

endpackage

// File: rtl/wire_sequencer_if.sv
// rtl/wire_sequencer_if.sv - player/display signal bundle for wire_sequencer
interface wire_sequencer_if;
    logic       start;
    logic       cut_valid;
    logic [2:0] cut_idx;
    logic       pause_in;
    logic [2:0] wire_to_cut;
    logic [2:0] curr_colour;
    logic [2:0] target_colour;
    logic       busy;
    logic       win;
    logic       lose;
    logic [7:0] score;

    modport master (
        output start, cut_valid, cut_idx, pause_in,
        input  wire_to_cut, curr_colour, target_colour, busy, win, lose, score
    );

    modport slave (
        input  start, cut_valid, cut_idx, pause_in,
        output wire_to_cut, curr_colour, target_colour, busy, win, lose, score
    );
endinterface

// File: rtl/wire_sequencer_lfsr8.sv
// rtl/wire_sequencer_lfsr8.sv - free-running 8-bit Fibonacci LFSR, never reaches all-zero
module lfsr8
    import wire_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] value
);

    logic feedback;

    assign feedback = ^(value & LFSR_TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else begin
            value <= {value[6:0], feedback};
        end
    end

endmodule

// File: rtl/wire_sequencer.sv
// rtl/wire_sequencer.sv - cut-the-wire game round sequencer with colour stepping and score
// Optional round timeout enabled by defining WIRE_SEQUENCER_TIMEOUT_EN.
module wire_sequencer
    import wire_sequencer_pkg::*;
#(
    parameter int NUM_WIRES     = 6,
    parameter int COLOUR_TICKS  = 50_000_000,
    parameter int TIMEOUT_STEPS = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    wire_sequencer_if.slave  bus
);

    localparam int                TICK_W    = (COLOUR_TICKS > 1) ? $clog2(COLOUR_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(COLOUR_TICKS - 1);

    state_t            state_q, state_d;
    logic [7:0]        lfsr;
    logic [2:0]        wire_q, wire_d;
    logic [2:0]        target_q, target_d;
    logic [2:0]        colour_q, colour_d;
    logic [2:0]        cut_idx_q, cut_idx_d;
    logic [2:0]        cut_col_q, cut_col_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [7:0]        score_q, score_d;
    logic              colour_step;
    logic              hit;
    logic              win;
    logic              lose;
    logic              unused_lfsr;

`ifdef WIRE_SEQUENCER_TIMEOUT_EN
    localparam int                STEP_W    = $clog2(TIMEOUT_STEPS + 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TIMEOUT_STEPS - 1);

    logic [STEP_W-1:0] step_q, step_d;
    logic              timed_out_q, timed_out_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= '0;
            timed_out_q <= 1'b0;
        end else begin
            step_q      <= step_d;
            timed_out_q <= timed_out_d;
        end
    end
`else
    logic timed_out_q;
    logic unused_timeout;

    assign timed_out_q    = 1'b0;
    assign unused_timeout = (TIMEOUT_STEPS > 0);
`endif

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .value (lfsr)
    );

    assign unused_lfsr = ^lfsr[7:6];
    assign colour_step = !bus.pause_in && (tick_q == TICK_LAST);
    assign hit         = (cut_idx_q == wire_q) && (cut_col_q == target_q);
    assign win         = (state_q == ST_CHECK) && !timed_out_q && hit;
    assign lose        = (state_q == ST_CHECK) && !win;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wire_q    <= '0;
            target_q  <= '0;
            colour_q  <= '0;
            cut_idx_q <= '0;
            cut_col_q <= '0;
            tick_q    <= '0;
            score_q   <= '0;
        end else begin
            state_q   <= state_d;
            wire_q    <= wire_d;
            target_q  <= target_d;
            colour_q  <= colour_d;
            cut_idx_q <= cut_idx_d;
            cut_col_q <= cut_col_d;
            tick_q    <= tick_d;
            score_q   <= score_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wire_d    = wire_q;
        target_d  = target_q;
        colour_d  = colour_q;
        cut_idx_d = cut_idx_q;
        cut_col_d = cut_col_q;
        tick_d    = tick_q;
        score_d   = score_q;
`ifdef WIRE_SEQUENCER_TIMEOUT_EN
        step_d      = step_q;
        timed_out_d = timed_out_q;
`endif

        // Colour keeps cycling in every state except ARM, including attract mode in IDLE.
        if (!bus.pause_in) begin
            if (colour_step) begin
                tick_d   = '0;
                colour_d = next_colour(colour_q);
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                tick_d   = '0;
                colour_d = colour_q;
`ifdef WIRE_SEQUENCER_TIMEOUT_EN
                step_d      = '0;
                timed_out_d = 1'b0;
`endif
                if ({1'b0, lfsr[2:0]} < 4'(NUM_WIRES)) begin
                    wire_d   = lfsr[2:0];
                    target_d = mod_colours(lfsr[5:3]);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // The cut is judged against the colour shown before any step on this edge.
                if (bus.cut_valid) begin
                    cut_idx_d = bus.cut_idx;
                    cut_col_d = colour_q;
                    state_d   = ST_CHECK;
                end
`ifdef WIRE_SEQUENCER_TIMEOUT_EN
                else if (colour_step) begin
                    if (step_q == STEP_LAST) begin
                        timed_out_d = 1'b1;
                        state_d     = ST_CHECK;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
`endif
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if (win && (score_q != 8'hFF)) begin
                    score_d = score_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.wire_to_cut   = wire_q;
    assign bus.curr_colour   = colour_q;
    assign bus.target_colour = target_q;
    assign bus.busy          = (state_q == ST_ARM) || (state_q == ST_RUN);
    assign bus.win           = win;
    assign bus.lose          = lose;
    assign bus.score         = score_q;

endmodule
